// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage: valid/ready register with a 2-entry skid buffer and a registered in_ready.
// Define PIPE_STAGE_PERF_EN to add the saturating stall_cnt / bubble_cnt performance counters.
module pipe_stage_elastic #(
    parameter int unsigned CTRL_W        = 12,
    parameter int unsigned PAYLOAD_W     = 175,
    parameter bit          CLEAR_PAYLOAD = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CTRL_W-1:0]    in_ctrl,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CTRL_W-1:0]    out_ctrl,
    output logic [PAYLOAD_W-1:0] out_payload
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]          stall_cnt,
    output logic [31:0]          bubble_cnt
`endif
);

    logic                 m_v_q, m_v_d;
    logic [CTRL_W-1:0]    m_ctrl_q, m_ctrl_d;
    logic [PAYLOAD_W-1:0] m_pay_q, m_pay_d;
    logic                 s_v_q, s_v_d;
    logic [CTRL_W-1:0]    s_ctrl_q, s_ctrl_d;
    logic [PAYLOAD_W-1:0] s_pay_q, s_pay_d;
    logic                 xfer_in;

    assign xfer_in = in_valid & ~s_v_q;

    always_comb begin
        m_v_d    = m_v_q;
        m_ctrl_d = m_ctrl_q;
        m_pay_d  = m_pay_q;
        s_v_d    = s_v_q;
        s_ctrl_d = s_ctrl_q;
        s_pay_d  = s_pay_q;
        if (flush) begin
            m_v_d    = 1'b0;
            s_v_d    = 1'b0;
            m_ctrl_d = '0;
            s_ctrl_d = '0;
            if (CLEAR_PAYLOAD) begin
                m_pay_d = '0;
                s_pay_d = '0;
            end
        end else if (!m_v_q || out_ready) begin
            // Skid always drains first so ordering stays FIFO
            if (s_v_q) begin
                m_v_d    = 1'b1;
                m_ctrl_d = s_ctrl_q;
                m_pay_d  = s_pay_q;
                s_v_d    = 1'b0;
                s_ctrl_d = '0;
            end else if (xfer_in) begin
                m_v_d    = 1'b1;
                m_ctrl_d = in_ctrl;
                m_pay_d  = in_payload;
            end else begin
                m_v_d    = 1'b0;
                m_ctrl_d = '0;
            end
        end else if (xfer_in) begin
            s_v_d    = 1'b1;
            s_ctrl_d = in_ctrl;
            s_pay_d  = in_payload;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_v_q    <= 1'b0;
            m_ctrl_q <= '0;
            m_pay_q  <= '0;
            s_v_q    <= 1'b0;
            s_ctrl_q <= '0;
            s_pay_q  <= '0;
        end else begin
            m_v_q    <= m_v_d;
            m_ctrl_q <= m_ctrl_d;
            m_pay_q  <= m_pay_d;
            s_v_q    <= s_v_d;
            s_ctrl_q <= s_ctrl_d;
            s_pay_q  <= s_pay_d;
        end
    end

    // Ready comes straight from the skid flop: no combinational path from out_ready
    assign in_ready    = ~s_v_q;
    assign out_valid   = m_v_q;
    assign out_ctrl    = m_ctrl_q & {CTRL_W{m_v_q}};
    assign out_payload = m_pay_q;

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cnt_q, bubble_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (m_v_q && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (!m_v_q && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
Generic, parametrised pipeline stage register with valid/ready handshake and a 2-entry skid buffer. It is the successor to the fixed-field decode/execute boundary register. Each boundary carries a control bundle (RegWrite, MemWrite, Jump, Branch, ResultSrc, ALUControl, …) and a data payload (operands, immediate, PC, register indices), each packed into one vector. Adds backpressure (stall), synchronous flush with bubble insertion, and a registered ready path, so the core can stall without combinational ready chains.

Parameters:
CTRL_W, 12, width of control bundle; zeroed on flush and on bubbles
PAYLOAD_W, 175, width of data payload (RD1, RD2, Imm, PC, PC+4, Rs1, Rs2, Rd)
CLEAR_PAYLOAD, 1, 1 = payload also zeroed on flush/reset; 0 = payload held (saves power/area)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
flush  in  1  synchronous flush, kills all held entries
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept; registered (= skid entry empty)
in_ctrl  in  CTRL_W  upstream control bundle
in_payload  in  PAYLOAD_W  upstream data payload
out_valid  out  1  output entry valid
out_ready  in  1  downstream accepts (0 = stall)
out_ctrl  out  CTRL_W  control bundle; forced 0 whenever out_valid=0
out_payload  out  PAYLOAD_W  data payload of output entry

Behaviour:
- Storage: main entry (m_v, m_ctrl, m_pay) drives the outputs; skid entry (s_v, s_ctrl, s_pay) absorbs one beat after a stall.
- Reset (async): m_v=s_v=0, all ctrl=0, payload=0. Outputs after reset: out_valid=0, out_ctrl=0, out_payload=0, in_ready=1.
- in_ready = ~s_v, taken directly from a flop with no combinational path from out_ready.
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- Latency: one cycle. An accepted beat into an empty or draining main entry appears on outputs the next cycle.
- Per-cycle update when flush=0:
  - Main empty or draining (~m_v | out_ready): main loads the skid entry if s_v (skid then clears); otherwise main loads the input if it transferred in; otherwise m_v becomes 0.
  - Main full and stalled (m_v & ~out_ready), with an input transfer: beat is written into skid, s_v=1.
  - Main full and stalled, no input: hold everything.
- Ordering is strictly FIFO. The skid entry always drains before new input reaches main.
- Max occupancy is 2. When s_v=1, in_ready=0, so no beat is ever dropped or overwritten.
- Flush has priority over every other event in the same cycle:
  - m_v=s_v=0 and both ctrl vectors are zeroed.
  - Payloads are zeroed if CLEAR_PAYLOAD=1, otherwise held.
  - A beat presented with in_valid that same cycle is discarded.
  - Next cycle: out_valid=0, out_ctrl=0, in_ready=1.
- Bubble guarantee: out_ctrl is AND-gated with out_valid, so a bubble can never assert RegWrite or MemWrite downstream.
- out_payload is undefined-but-stable when out_valid=0. With CLEAR_PAYLOAD=1 it is 0 after flush/reset.
- Reset asserted mid-stall drops both entries immediately (asynchronous).
- in_valid is not required to hold while in_ready=0. The stage samples only on transfer.

Optional Feature:
PIPE_STAGE_PERF_EN
- Defined: adds ports stall_cnt (out, 32) and bubble_cnt (out, 32), both saturating at 32'hFFFF_FFFF and reset to 0.
  - stall_cnt increments each cycle with out_valid & ~out_ready.
  - bubble_cnt increments each cycle with ~out_valid (flush-induced or starvation).
  - flush does not clear the counters.
- Undefined: the ports and counters do not exist. Behaviour is otherwise identical.

Test Plan:
- Reset → out_valid=0, out_ctrl=0, out_payload=0, in_ready=1. Release rst_n, drive in_valid=1, ctrl=12'hABC, payload=A every cycle with out_ready=1 → out_ctrl=12'hABC one cycle later, one beat per cycle, no gaps.
- Stall: stream beats 1,2,3, drop out_ready for 3 cycles at beat 1 → beat 2 enters skid, in_ready=0 the next cycle, beat 3 held upstream. Raise out_ready → outputs 1,2,3 in order, no loss or duplication.
- Flush while both entries full (beats 5,6) with in_valid=1 carrying beat 7 → next cycle out_valid=0, out_ctrl=0, in_ready=1. Beats 5,6,7 never appear on the outputs.
- Flush and out_ready=0 in the same cycle as an input transfer → flush wins and occupancy is 0. With CLEAR_PAYLOAD=0, out_payload holds its old value while out_ctrl=0.
- Async reset asserted mid-stall with occupancy 2 → outputs go to reset values immediately without a clock edge.
- With PIPE_STAGE_PERF_EN: 4 stall cycles then 2 idle cycles → stall_cnt=4, bubble_cnt=2. Preload near saturation → counter stays at FFFF_FFFF.
